activation_scheduler: RTL and testbench

Command-driven sequencer that sits directly upstream of the activation buffer bank and drives its `start`, `last_row`, `addr_start` and `batch` inputs. It accepts one layer command (base address, row count, batch, tile count, stride) over a valid/ready handshake. It then issues one start pulse per tile, watching lane 0 of `activation_in_valid` (the last lane to stream, because start propagates downward from `last_row`) to detect tile completion before issuing the next. Completion and error are reported with a one-cycle `done` pulse and a sticky `err`.

---
 rtl/activation_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_activation_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_scheduler.sv
// activation_scheduler
//
// Command-driven sequencer for the activation buffer bank. It accepts one layer
// command, then issues one start pulse per tile. Tile completion is tracked on
// activation_in_valid[0]: lane 0 streams last, because start ripples down from
// last_row. A one-cycle done pulse ends every command. err is sticky until the
// next accepted command and is set when a tile never produces valid data.
//
// Parameters
//   ADDR_W      width of addr_start and of the address arithmetic (wraps silently)
//   BATCH_W     width of batch
//   GAP_CYCLES  idle cycles between the end of one tile and the next start (0 allowed)
//   TIMEOUT     cycles allowed in WAIT_FIRST before the command is aborted (>= 1)
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only while idle
//   cmd_base, cmd_stride  tile 0 address and per-tile address increment
//   cmd_last_row          highest active lane, forwarded as last_row
//   cmd_batch             batch forwarded to the buffers
//   cmd_tiles             number of tiles (0 completes immediately)
//   hold                  downstream stall, only blocks issuing a start
//   activation_in_valid   per-lane valid from the buffer bank (bit 0 only)
//   start                 one-cycle start pulse per tile
//   last_row, addr_start, batch   registered tile parameters
//   busy, tile_idx        status
//   done, err             completion pulse and sticky timeout flag

module activation_scheduler #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned BATCH_W    = 6,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_base,
  input  logic [ADDR_W-1:0]  cmd_stride,
  input  logic [4:0]         cmd_last_row,
  input  logic [BATCH_W-1:0] cmd_batch,
  input  logic [7:0]         cmd_tiles,
  input  logic               hold,
  input  logic [31:0]        activation_in_valid,
  output logic               start,
  output logic [4:0]         last_row,
  output logic [ADDR_W-1:0]  addr_start,
  output logic [BATCH_W-1:0] batch,
  output logic               busy,
  output logic [7:0]         tile_idx,
  output logic               done,
  output logic               err
);

  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitFirst,
    StWaitDrain,
    StGap,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [ToW-1:0]     to_cnt_q, to_cnt_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]         tiles_q, tiles_d;
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [4:0]         last_row_q, last_row_d;
  logic [BATCH_W-1:0] batch_q, batch_d;
  logic [7:0]         tile_idx_q, tile_idx_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic valid0;
  logic last_tile;
  logic to_expired;
  logic gap_expired;

  // Only lane 0 matters; the remaining lanes are deliberately ignored.
  logic unused_valid_hi;
  assign unused_valid_hi = ^activation_in_valid[31:1];

  assign valid0      = activation_in_valid[0];
  assign last_tile   = (tile_idx_q + 8'd1) == tiles_q;
  assign to_expired  = to_cnt_q == ToW'(TIMEOUT - 1);
  assign gap_expired = gap_cnt_q == GapW'(GAP_CYCLES - 1);

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tiles_d    = tiles_q;
    stride_d   = stride_q;
    addr_d     = addr_q;
    last_row_d = last_row_q;
    batch_d    = batch_q;
    tile_idx_d = tile_idx_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          tiles_d    = cmd_tiles;
          stride_d   = cmd_stride;
          addr_d     = cmd_base;
          last_row_d = cmd_last_row;
          batch_d    = cmd_batch;
          tile_idx_d = 8'd0;
          err_d      = 1'b0;
          state_d    = (cmd_tiles == 8'd0) ? StDone : StIssue;
        end
      end

      StIssue: begin
        if (!hold) begin
          start_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = StWaitFirst;
        end
      end

      StWaitFirst: begin
        // valid wins over an expiring counter in the same cycle.
        if (valid0) begin
          state_d = StWaitDrain;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end

      StWaitDrain: begin
        if (!valid0) begin
          if (last_tile) begin
            state_d = StDone;
          end else begin
            tile_idx_d = tile_idx_q + 8'd1;
            addr_d     = addr_q + stride_q;
            if (GAP_CYCLES == 0) begin
              state_d = StIssue;
            end else begin
              gap_cnt_d = '0;
              state_d   = StGap;
            end
          end
        end
      end

      StGap: begin
        if (gap_expired) begin
          state_d = StIssue;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end

      StDone: begin
        // done is registered, so it is visible in the first idle cycle.
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      tiles_q    <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
      last_row_q <= '0;
      batch_q    <= '0;
      tile_idx_q <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tiles_q    <= tiles_d;
      stride_q   <= stride_d;
      addr_q     <= addr_d;
      last_row_q <= last_row_d;
      batch_q    <= batch_d;
      tile_idx_q <= tile_idx_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready  = state_q == StIdle;
  assign busy       = state_q != StIdle;
  assign start      = start_q;
  assign done       = done_q;
  assign err        = err_q;
  assign last_row   = last_row_q;
  assign addr_start = addr_q;
  assign batch      = batch_q;
  assign tile_idx   = tile_idx_q;

  // Pulses never stretch, and a start always belongs to an accepted command.
  a_start_pulse : assert property (@(posedge clk) disable iff (!resetn) start |=> !start);
  a_done_pulse  : assert property (@(posedge clk) disable iff (!resetn) done |=> !done);
  a_start_busy  : assert property (@(posedge clk) disable iff (!resetn) start |-> busy);

endmodule

// File: tb/tb_activation_scheduler.sv
module tb_activation_scheduler;

  localparam int AW = 11;
  localparam int BW = 6;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          sel = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW-1:0] cmd_stride = '0;
  logic [4:0]    cmd_last_row = '0;
  logic [BW-1:0] cmd_batch = '0;
  logic [7:0]    cmd_tiles = '0;
  logic          hold = 1'b0;
  logic [31:0]   act_valid = '0;

  // Two instances: defaults (GAP 2, TIMEOUT 1024) and a short-timeout, no-gap one.
  logic cv_a, cv_t;
  assign cv_a = cmd_valid & ~sel;
  assign cv_t = cmd_valid & sel;

  logic a_rdy, a_start, a_busy, a_done, a_err;
  logic [4:0] a_lr;
  logic [AW-1:0] a_addr;
  logic [BW-1:0] a_batch;
  logic [7:0] a_ti;
  logic t_rdy, t_start, t_busy, t_done, t_err;
  logic [4:0] t_lr;
  logic [AW-1:0] t_addr;
  logic [BW-1:0] t_batch;
  logic [7:0] t_ti;

  activation_scheduler #(
    .ADDR_W(AW), .BATCH_W(BW), .GAP_CYCLES(2), .TIMEOUT(1024)
  ) dut_a (
    .clk(clk), .resetn(resetn), .cmd_valid(cv_a), .cmd_ready(a_rdy),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_last_row(cmd_last_row),
    .cmd_batch(cmd_batch), .cmd_tiles(cmd_tiles), .hold(hold),
    .activation_in_valid(act_valid), .start(a_start), .last_row(a_lr),
    .addr_start(a_addr), .batch(a_batch), .busy(a_busy), .tile_idx(a_ti),
    .done(a_done), .err(a_err)
  );

  activation_scheduler #(
    .ADDR_W(AW), .BATCH_W(BW), .GAP_CYCLES(0), .TIMEOUT(16)
  ) dut_t (
    .clk(clk), .resetn(resetn), .cmd_valid(cv_t), .cmd_ready(t_rdy),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_last_row(cmd_last_row),
    .cmd_batch(cmd_batch), .cmd_tiles(cmd_tiles), .hold(hold),
    .activation_in_valid(act_valid), .start(t_start), .last_row(t_lr),
    .addr_start(t_addr), .batch(t_batch), .busy(t_busy), .tile_idx(t_ti),
    .done(t_done), .err(t_err)
  );

  logic o_rdy, o_start, o_busy, o_done, o_err;
  logic [4:0] o_lr;
  logic [AW-1:0] o_addr;
  logic [BW-1:0] o_batch;
  logic [7:0] o_ti;
  assign o_rdy   = sel ? t_rdy   : a_rdy;
  assign o_start = sel ? t_start : a_start;
  assign o_busy  = sel ? t_busy  : a_busy;
  assign o_done  = sel ? t_done  : a_done;
  assign o_err   = sel ? t_err   : a_err;
  assign o_lr    = sel ? t_lr    : a_lr;
  assign o_addr  = sel ? t_addr  : a_addr;
  assign o_batch = sel ? t_batch : a_batch;
  assign o_ti    = sel ? t_ti    : a_ti;

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [4:0]    lr;
    logic [BW-1:0] batch;
    logic [7:0]    tiles;
  } cmd_t;

  typedef struct {
    bit            sel;
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [4:0]    lr;
    logic [BW-1:0] batch;
    logic [7:0]    tiles;
    int            d;
    int            l;
    int            exp_starts;
    logic [AW-1:0] exp_addr;
    logic          exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Stimulus script for one command, indexed by edge number after the accept edge.
  bit hold_t[0:4095];
  int d_t[0:7];      // edges from start until valid[0] is first sampled high
  int l_t[0:7];      // edges valid[0] stays high
  // Predicted event edges.
  int s_e[0:7];
  int f_e[0:7];
  int n_st, d_edge, to_edge;
  int st_seen[0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic st, input logic dn, input logic er,
                                       input logic bz, input logic rdy, input logic [7:0] ti,
                                       input logic [AW-1:0] ad, input logic [4:0] lr,
                                       input logic [BW-1:0] bt);
    return {29'd0, st, dn, er, bz, rdy, ti, ad, lr, bt};
  endfunction

  function automatic logic [63:0] obs();
    return pack(o_start, o_done, o_err, o_busy, o_rdy, o_ti, o_addr, o_lr, o_batch);
  endfunction

  task automatic clear_script();
    for (int i = 0; i < 4096; i++) hold_t[i] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d_t[k] = 1;
      l_t[k] = 1;
    end
  endtask

  // Event times from the command rules: start one edge after ISSUE is entered and
  // hold is low; tile ends when valid drops; next ISSUE after gap; timeout aborts.
  task automatic plan(input int tiles, input int gap, input int to);
    int i_e, s;
    n_st = 0;
    to_edge = -1;
    d_edge = 1;
    if (tiles == 0) return;
    i_e = 0;
    for (int k = 0; k < tiles; k++) begin
      s = i_e + 1;
      while (s < 4095 && hold_t[s]) s++;
      s_e[k] = s;
      n_st++;
      if (d_t[k] > to) begin
        to_edge = s + to;
        d_edge  = to_edge + 1;
        return;
      end
      f_e[k] = s + d_t[k] + l_t[k];
      if (k == tiles - 1) d_edge = f_e[k] + 1;
      else i_e = f_e[k] + gap;
    end
  endtask

  function automatic bit vexp(input int e);
    for (int k = 0; k < n_st; k++)
      if (e >= s_e[k] + d_t[k] && e < s_e[k] + d_t[k] + l_t[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] expect_at(input int e, input cmd_t c);
    logic st;
    int ti;
    logic [AW-1:0] ad;
    st = 1'b0;
    ti = 0;
    for (int k = 0; k < n_st; k++) begin
      if (s_e[k] == e) st = 1'b1;
      if (k < int'(c.tiles) - 1 && !(to_edge >= 0 && k == n_st - 1) && f_e[k] <= e) ti++;
    end
    ad = AW'(int'(c.base) + int'(c.stride) * ti);
    return pack(st, e == d_edge, to_edge >= 0 && e >= to_edge, e < d_edge, e >= d_edge,
                8'(ti), ad, c.lr, c.batch);
  endfunction

  task automatic drive_cmd(input cmd_t c);
    cmd_base     = c.base;
    cmd_stride   = c.stride;
    cmd_last_row = c.lr;
    cmd_batch    = c.batch;
    cmd_tiles    = c.tiles;
  endtask

  task automatic drive_valid(input bit v0);
    logic [31:0] r;
    r = $urandom;
    act_valid = {r[31:1], v0};
  endtask

  task automatic do_reset();
    logic [63:0] rst_exp;
    rst_exp = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, '0, 5'd0, '0);
    resetn = 1'b0;
    #1;
    chk("async reset", obs(), rst_exp);
    cmd_valid = 1'b0;
    hold = 1'b0;
    act_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("held in reset", obs(), rst_exp);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset release", obs(), rst_exp);
  endtask

  // Present c (accepted at the next edge), then check every cycle until done.
  task automatic run_cmd(input cmd_t c, input bit s, input bit nxt_v, input cmd_t nxt,
                         input int abort_at, output int starts,
                         output logic [AW-1:0] addr_fin, output logic err_fin);
    plan(int'(c.tiles), s ? 0 : 2, s ? 16 : 1024);
    sel = s;
    drive_cmd(c);
    cmd_valid = 1'b1;
    hold = 1'b0;
    drive_valid(1'b0);
    starts = 0;
    addr_fin = '0;
    err_fin = 1'b0;
    for (int e = 0; e <= d_edge; e++) begin
      @(posedge clk); #1;
      chk($sformatf("cycle %0d of cmd base %h", e, c.base), obs(), expect_at(e, c));
      if (o_start) begin
        if (starts < 8) st_seen[starts] = e;
        starts++;
      end
      addr_fin = o_addr;
      err_fin  = o_err;
      if (e == abort_at) begin
        do_reset();
        return;
      end
      cmd_valid = nxt_v;
      if (nxt_v) drive_cmd(nxt);
      hold = hold_t[e+1];
      drive_valid(vexp(e + 1));
    end
    cmd_valid = 1'b0;
  endtask

  vec_t tbl[0:5];
  cmd_t c0, c1;
  int   n_starts;
  logic [AW-1:0] a_fin;
  logic e_fin;

  initial begin
    tbl[0] = '{0, 11'h040, 11'h000, 5'd31, 6'd4,  8'd1, 33,  4, 1, 11'h040, 1'b0};
    tbl[1] = '{0, 11'h7F0, 11'h008, 5'd7,  6'd9,  8'd3, 3,   5, 3, 11'h000, 1'b0};
    tbl[2] = '{0, 11'h123, 11'h010, 5'd2,  6'd1,  8'd0, 5,   5, 0, 11'h123, 1'b0};
    tbl[3] = '{0, 11'h005, 11'h7FF, 5'd16, 6'd63, 8'd2, 1,   1, 2, 11'h004, 1'b0};
    tbl[4] = '{1, 11'h3A0, 11'h004, 5'd9,  6'd5,  8'd2, 100, 1, 1, 11'h3A0, 1'b1};
    tbl[5] = '{1, 11'h3A0, 11'h004, 5'd9,  6'd5,  8'd3, 2,   2, 3, 11'h3A8, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset values", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, '0, 5'd0, '0));
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, '0, 5'd0, '0));

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      clear_script();
      for (int k = 0; k < 8; k++) begin
        d_t[k] = tbl[i].d;
        l_t[k] = tbl[i].l;
      end
      c0 = '{tbl[i].base, tbl[i].stride, tbl[i].lr, tbl[i].batch, tbl[i].tiles};
      run_cmd(c0, tbl[i].sel, 1'b0, c0, -1, n_starts, a_fin, e_fin);
      chk($sformatf("tbl%0d start count", i), 64'(n_starts), 64'(tbl[i].exp_starts));
      chk($sformatf("tbl%0d final addr", i), 64'(a_fin), 64'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d err", i), 64'(e_fin), 64'(tbl[i].exp_err));
      if (tbl[i].exp_starts > 1)
        chk($sformatf("tbl%0d start spacing", i), 64'(st_seen[1] - st_seen[0]),
            64'(tbl[i].d + tbl[i].l + (tbl[i].sel ? 1 : 3)));
    end

    // Hold at ISSUE of the second tile, hold during a drain, second command waiting.
    clear_script();
    for (int k = 0; k < 8; k++) begin
      d_t[k] = 3;
      l_t[k] = 5;
    end
    for (int i = 5; i <= 7; i++) hold_t[i] = 1'b1;
    for (int i = 12; i <= 16; i++) hold_t[i] = 1'b1;
    c0 = '{11'h100, 11'h020, 5'd12, 6'd33, 8'd3};
    c1 = '{11'h222, 11'h001, 5'd3, 6'd2, 8'd1};
    run_cmd(c0, 1'b0, 1'b1, c1, -1, n_starts, a_fin, e_fin);
    chk("hold start count", 64'(n_starts), 64'd3);
    chk("hold delays tile 2 start", 64'(st_seen[1] - st_seen[0]), 64'd16);
    chk("hold final addr", 64'(a_fin), 64'h140);
    clear_script();
    d_t[0] = 2;
    l_t[0] = 2;
    run_cmd(c1, 1'b0, 1'b0, c1, -1, n_starts, a_fin, e_fin);
    chk("queued cmd start count", 64'(n_starts), 64'd1);
    chk("queued cmd addr", 64'(a_fin), 64'h222);

    // Reset during the drain of the second tile, then a fresh command.
    clear_script();
    for (int k = 0; k < 8; k++) begin
      d_t[k] = 3;
      l_t[k] = 6;
    end
    c0 = '{11'h300, 11'h010, 5'd20, 6'd7, 8'd3};
    run_cmd(c0, 1'b0, 1'b0, c0, 18, n_starts, a_fin, e_fin);
    clear_script();
    d_t[0] = 4;
    l_t[0] = 3;
    c0 = '{11'h055, 11'h001, 5'd5, 6'd1, 8'd1};
    run_cmd(c0, 1'b0, 1'b0, c0, -1, n_starts, a_fin, e_fin);
    chk("post-reset start count", 64'(n_starts), 64'd1);
    chk("post-reset addr", 64'(a_fin), 64'h055);

    // Randomized commands against the event-time model.
    for (int r = 0; r < 40; r++) begin
      bit s;
      s = 1'($urandom_range(0, 1));
      clear_script();
      for (int k = 0; k < 8; k++) begin
        d_t[k] = 1 + $urandom_range(0, s ? 19 : 39);
        l_t[k] = 1 + $urandom_range(0, 5);
      end
      for (int i = 0; i < 600; i++) hold_t[i] = ($urandom_range(0, 3) == 0);
      c0.base   = AW'($urandom);
      c0.stride = AW'($urandom);
      c0.lr     = 5'($urandom);
      c0.batch  = BW'($urandom);
      c0.tiles  = 8'($urandom_range(0, 4));
      run_cmd(c0, s, 1'b0, c0, -1, n_starts, a_fin, e_fin);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
